// File: rtl/hs_pkg.sv
// Shared types and helpers for the round-robin 4-phase handshake arbiter.
// Holds the FSM state encoding and the index-to-one-hot helper.
package hs_pkg;

   localparam int MAX_N = 16;
   localparam int IDX_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_RTZ  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      HOLD = ST_HOLD,
      RTZ  = ST_RTZ
   } hs_arb_state_t;

   // Callers cast the result down to their own requester count.
   function automatic logic [MAX_N-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [MAX_N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Bundle of requester-side and downstream-side handshake signals of the arbiter.
// The master modport is the environment; the slave modport is the arbiter itself.
interface hs_rr_arbiter_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int PW = $clog2(N)
) ();

   logic [N-1:0]    req_i;
   logic [N-1:0]    ack_o;
   logic [N*DW-1:0] data_i;
   logic            rout;
   logic            ain;
   logic [DW-1:0]   dout;
   logic [N-1:0]    gnt_o;
   logic [PW-1:0]   gnt_idx;
   logic            cap;
   logic            busy;
   logic            err;

   modport master (
      output req_i, data_i, ain,
      input  ack_o, rout, dout, gnt_o, gnt_idx, cap, busy, err
   );

   modport slave (
      input  req_i, data_i, ain,
      output ack_o, rout, dout, gnt_o, gnt_idx, cap, busy, err
   );

endinterface

// File: rtl/hs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Handles non-power-of-two N by explicit wrap of the search index.
module hs_rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   int            j;
   logic [PW-1:0] jj;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      jj    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         jj = PW'(j);
         if (req[jj]) begin
            valid = 1'b1;
            idx   = jj;
         end
      end
   end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one downstream 4-phase handshake among N requesters.
// Define HS_ARB_SYNC_EN to pass req_i and ain through 2-flop synchronizers.
module hs_rr_arbiter
   import hs_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int PW = $clog2(N)
) (
   input logic              clk,
   input logic              rst,
   hs_rr_arbiter_if.slave   bus
);

   logic [N-1:0] req_s;
   logic         ain_s;

`ifdef HS_ARB_SYNC_EN
   logic [N-1:0] req_m;
   logic         ain_m;

   always_ff @(posedge clk) begin
      if (!rst) begin
         req_m <= '0;
         req_s <= '0;
         ain_m <= 1'b0;
         ain_s <= 1'b0;
      end else begin
         req_m <= bus.req_i;
         req_s <= req_m;
         ain_m <= bus.ain;
         ain_s <= ain_m;
      end
   end
`else
   assign req_s = bus.req_i;
   assign ain_s = bus.ain;
`endif

   hs_arb_state_t state_q, state_d;
   logic          rout_q, rout_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [PW-1:0] idx_q, idx_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          cap_q, cap_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          err_q, err_d;

   logic          pick_valid;
   logic [PW-1:0] pick_idx;

   hs_rr_pick #(.N(N), .PW(PW)) u_pick (
      .req   (req_s),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      rout_d  = rout_q;
      ack_d   = ack_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      cap_d   = 1'b0;
      ptr_d   = ptr_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (ain_s) err_d = 1'b1;
            if (pick_valid) begin
               dout_d  = bus.data_i[pick_idx*DW +: DW];
               cap_d   = 1'b1;
               rout_d  = 1'b1;
               gnt_d   = N'(onehot(IDX_W'(pick_idx)));
               idx_d   = pick_idx;
               state_d = REQ;
            end
         end
         REQ: begin
            if (!req_s[idx_q]) err_d = 1'b1;
            if (ain_s) begin
               ack_d   = gnt_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!ain_s) err_d = 1'b1;
            if (!req_s[idx_q]) begin
               rout_d  = 1'b0;
               state_d = RTZ;
            end
         end
         RTZ: begin
            // Upstream ack only drops once downstream has returned to zero.
            if (!ain_s) begin
               ack_d   = '0;
               gnt_d   = '0;
               ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!rst) begin
         state_q <= IDLE;
         rout_q  <= 1'b0;
         ack_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
         cap_q   <= 1'b0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rout_q  <= rout_d;
         ack_q   <= ack_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         cap_q   <= cap_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign bus.rout    = rout_q;
   assign bus.ack_o   = ack_q;
   assign bus.gnt_o   = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.dout    = dout_q;
   assign bus.cap     = cap_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.err     = err_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed self-checking bench for hs_rr_arbiter (N=4, DW=8).
// Expected latencies follow HS_ARB_SYNC_EN when the bench is built with it.
module tb_hs_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int PW = 2;
`ifdef HS_ARB_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int BUDGET = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hs_rr_arbiter_if #(.N(N), .DW(DW), .PW(PW)) bus ();

   hs_rr_arbiter #(.N(N), .DW(DW), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] dat [N] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      bus.req_i  = '0;
      bus.ain    = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_rout(input string tag, input logic lvl, output int n);
      n = 0;
      while (bus.rout !== lvl && n < BUDGET) begin
         tick();
         n++;
      end
      if (bus.rout !== lvl) check({tag, " rout timeout"}, 32'(bus.rout), 32'(lvl));
   endtask

   task automatic wait_ack(input string tag, input logic nz, output int n);
      n = 0;
      while ((bus.ack_o != '0) !== nz && n < BUDGET) begin
         tick();
         n++;
      end
      if ((bus.ack_o != '0) !== nz) check({tag, " ack timeout"}, 32'(bus.ack_o != '0), 32'(nz));
   endtask

   // Full transaction for requester g, which must be the next winner.
   task automatic serve(input int g, input string tag);
      int n;
      logic [N-1:0] oh;
      oh = N'(1) << g;
      wait_rout(tag, 1'b1, n);
      check({tag, " idx"}, 32'(bus.gnt_idx), g);
      check({tag, " gnt"}, 32'(bus.gnt_o), 32'(oh));
      check({tag, " dout"}, 32'(bus.dout), 32'(dat[g]));
      bus.ain = 1'b1;
      wait_ack(tag, 1'b1, n);
      check({tag, " ack"}, 32'(bus.ack_o), 32'(oh));
      bus.req_i[g] = 1'b0;
      wait_rout(tag, 1'b0, n);
      bus.ain = 1'b0;
      wait_ack(tag, 1'b0, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.req_i  = '0;
      bus.ain    = 1'b0;
      bus.data_i = {dat[3], dat[2], dat[1], dat[0]};

      // Reset state
      tick();
      tick();
      check("rst rout", 32'(bus.rout), 0);
      check("rst ack", 32'(bus.ack_o), 0);
      check("rst dout", 32'(bus.dout), 0);
      check("rst gnt", 32'(bus.gnt_o), 0);
      check("rst idx", 32'(bus.gnt_idx), 0);
      check("rst cap", 32'(bus.cap), 0);
      check("rst busy", 32'(bus.busy), 0);
      check("rst err", 32'(bus.err), 0);
      rst = 1'b1;
      tick();

      // Single requester
      bus.req_i = 4'b0001;
      wait_rout("t1", 1'b1, n);
      check("t1 req->rout lat", n, LAT);
      check("t1 dout", 32'(bus.dout), 32'h A5);
      check("t1 cap", 32'(bus.cap), 1);
      check("t1 gnt", 32'(bus.gnt_o), 1);
      check("t1 busy", 32'(bus.busy), 1);
      check("t1 ack early", 32'(bus.ack_o), 0);
      tick();
      check("t1 cap pulse", 32'(bus.cap), 0);
      tick();
      bus.ain = 1'b1;
      wait_ack("t1", 1'b1, n);
      check("t1 ain->ack lat", n, LAT);
      check("t1 ack", 32'(bus.ack_o), 32'b0001);
      bus.req_i = '0;
      wait_rout("t1", 1'b0, n);
      check("t1 ack held", 32'(bus.ack_o), 32'b0001);
      check("t1 err", 32'(bus.err), 0);
      tick();
      check("t1 ack before ain fall", 32'(bus.ack_o), 32'b0001);
      bus.ain = 1'b0;
      wait_ack("t1", 1'b0, n);
      check("t1 ain fall->ack lat", n, LAT);
      check("t1 gnt clear", 32'(bus.gnt_o), 0);
      check("t1 idle", 32'(bus.busy), 0);
      // Pointer now 1: requester 1 beats requester 0
      bus.req_i = 4'b0011;
      serve(1, "t1 ptr");
      serve(0, "t1 next");

      // Simultaneous requests from ptr=0
      do_reset();
      bus.req_i = 4'b1111;
      serve(0, "t2 g0");
      bus.req_i[0] = 1'b1;
      serve(1, "t2 g1");
      serve(2, "t2 g2");
      serve(3, "t2 g3");
      serve(0, "t2 g0b");
      check("t2 err", 32'(bus.err), 0);

      // Wrap from ptr=3
      do_reset();
      bus.req_i = 4'b0100;
      serve(2, "t3 setup");
      bus.req_i = 4'b1001;
      serve(3, "t3 g3");
      serve(0, "t3 g0");

      // Violation: req dropped in REQ
      do_reset();
      bus.req_i = 4'b0001;
      wait_rout("t4", 1'b1, n);
      check("t4 err before", 32'(bus.err), 0);
      bus.req_i = '0;
      repeat (LAT + 1) tick();
      check("t4 err req drop", 32'(bus.err), 1);
      bus.ain = 1'b1;
      wait_ack("t4", 1'b1, n);
      wait_rout("t4", 1'b0, n);
      bus.ain = 1'b0;
      wait_ack("t4", 1'b0, n);
      repeat (3) tick();
      check("t4 err sticky", 32'(bus.err), 1);
      check("t4 idle", 32'(bus.busy), 0);

      // Violation: ain high in IDLE
      do_reset();
      check("t4b err clear", 32'(bus.err), 0);
      bus.ain = 1'b1;
      repeat (LAT + 1) tick();
      check("t4b err ain idle", 32'(bus.err), 1);
      bus.ain = 1'b0;
      repeat (3) tick();
      check("t4b err sticky", 32'(bus.err), 1);
      check("t4b idle", 32'(bus.busy), 0);

      // Reset during HOLD
      do_reset();
      bus.req_i = 4'b0010;
      serve(1, "t5 setup");
      bus.req_i = 4'b0100;
      wait_rout("t5", 1'b1, n);
      check("t5 idx", 32'(bus.gnt_idx), 2);
      bus.ain = 1'b1;
      wait_ack("t5", 1'b1, n);
      check("t5 ack", 32'(bus.ack_o), 32'b0100);
      rst       = 1'b0;
      bus.ain   = 1'b0;
      bus.req_i = '0;
      tick();
      check("t5 rout", 32'(bus.rout), 0);
      check("t5 ack clr", 32'(bus.ack_o), 0);
      check("t5 busy", 32'(bus.busy), 0);
      check("t5 err", 32'(bus.err), 0);
      check("t5 gnt", 32'(bus.gnt_o), 0);
      rst = 1'b1;
      tick();
      bus.req_i = 4'b0101;
      serve(0, "t5 after g0");
      serve(2, "t5 after g2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
